// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// The state register drives Moore-style datapath controls. The exceptions are:
//   - FETCH write enables, which are gated by mem_ready;
//   - the BRANCH decision, which uses the ALU zero flag;
//   - fields taken from the instruction register (alu_funct, immediate mode).
module mips_multicycle_ctrl #(
    parameter int IDLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       zero_ext,
    output logic       shamt16,
    output logic [1:0] alu_op,
    output logic [5:0] alu_funct,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPE_EX, S_ALUWB_R, S_IEX, S_ALUWB_I, S_BRANCH, S_JUMP, S_JR
    } state_t;

    localparam logic [3:0] IDLE_LAST = 4'(IDLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] idle_cnt, idle_cnt_nxt;
    logic       illegal_nxt;
    logic       funct_ok;
    logic       op_itype;

    // Opcode and funct legality classification used by DECODE.
    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            6'd0, 6'd2, 6'd3, 6'd8, 6'd32, 6'd34,
            6'd36, 6'd37, 6'd38, 6'd39, 6'd42: funct_ok = 1'b1;
            default:                           funct_ok = 1'b0;
        endcase
        op_itype = (opcode == 6'h08) || (opcode == 6'h0A) ||
                   (opcode[5:2] == 4'b0011);
    end

    // State, idle counter and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idle_cnt <= '0;
            illegal  <= 1'b0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_cnt_nxt;
            illegal  <= illegal_nxt;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = idle_cnt;
        illegal_nxt  = illegal;
        case (state)
            S_IDLE: begin
                // An illegal instruction parks the FSM here until reset.
                if (!illegal) begin
                    if (idle_cnt == IDLE_LAST) begin
                        state_nxt    = S_FETCH;
                        idle_cnt_nxt = '0;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 4'd1;
                    end
                end
            end
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                if (opcode == 6'h23 || opcode == 6'h2B) begin
                    state_nxt = S_MEMADR;
                end else if (opcode == 6'h00 && funct_ok) begin
                    state_nxt = (funct == 6'h08) ? S_JR : S_RTYPE_EX;
                end else if (opcode == 6'h04 || opcode == 6'h05) begin
                    state_nxt = S_BRANCH;
                end else if (opcode == 6'h02) begin
                    state_nxt = S_JUMP;
                end else if (op_itype) begin
                    state_nxt = S_IEX;
                end else begin
                    illegal_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_MEMADR:   state_nxt = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWR:    if (mem_ready) state_nxt = S_FETCH;
            S_RTYPE_EX: state_nxt = S_ALUWB_R;
            S_IEX:      state_nxt = S_ALUWB_I;
            S_MEMWB, S_ALUWB_R, S_ALUWB_I,
            S_BRANCH, S_JUMP, S_JR: state_nxt = S_FETCH;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Datapath control decode; every control defaults to 0.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        zero_ext   = 1'b0;
        shamt16    = 1'b0;
        alu_op     = 2'b00;
        alu_funct  = 6'd0;
        case (state)
            S_FETCH: begin
                // PC+4 is computed while the instruction is read.
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:  alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                alu_funct = funct;
            end
            S_ALUWB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                alu_funct = opcode;
                zero_ext  = (opcode[5:2] == 4'b0011);
                shamt16   = (opcode == 6'h0F);
            end
            S_ALUWB_I: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_write  = ((opcode == 6'h04) && zero) ||
                            ((opcode == 6'h05) && !zero);
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            S_JR: begin
                pc_src   = 2'b11;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
